// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide controller: iterative shift-add multiply, restoring divide, MTHI/MTLO.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply (IDLE -> WB).
module muldiv_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        hi_we,
   output logic        lo_we,
   output logic        stall_req,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WB} state_e;
   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   state_e      state, state_nxt;
   logic [5:0]  cnt;
   logic [31:0] divisor;
   logic [63:0] acc;
   logic        neg_hi, neg_lo, is_div, dz;

   logic        is_mul_op, is_div_op, signed_op, a_neg, b_neg, b_zero, accept;
   logic [31:0] a_mag, b_mag, fix_hi, fix_lo;
   logic [32:0] mul_sum, div_diff;
   logic [63:0] mul_step, div_step, fix_val;

   always_comb begin
      is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
      is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = signed_op & src_a[31];
      b_neg     = signed_op & src_b[31];
      a_mag     = a_neg ? -src_a : src_a;
      b_mag     = b_neg ? -src_b : src_b;
      b_zero    = (src_b == '0);
      accept    = (state == IDLE) && start && !flush && (is_mul_op || is_div_op);
   end

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
      mul_step = {mul_sum, acc[31:1]};
      div_diff = acc[63:31] - {1'b0, divisor};
      div_step = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
      fix_hi   = neg_hi ? -acc[63:32] : acc[63:32];
      fix_lo   = neg_lo ? -acc[31:0]  : acc[31:0];
      fix_val  = is_div ? {fix_hi, fix_lo} : (neg_lo ? -acc : acc);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_prod;
   always_comb fast_prod = 64'(a_mag) * 64'(b_mag);
`endif

   always_comb begin
      state_nxt = state;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      hi_wdata  = '0;
      lo_wdata  = '0;
      done      = 1'b0;
      div_zero  = 1'b0;
      busy      = (state != IDLE);
      stall_req = accept || (state == MUL) || (state == DIV) || (state == FIX);
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (op == OP_MTHI) begin
                  hi_we    = 1'b1;
                  hi_wdata = src_a;
               end else if (op == OP_MTLO) begin
                  lo_we    = 1'b1;
                  lo_wdata = src_a;
               end else if (is_mul_op) begin
`ifdef MULDIV_FAST_MUL_EN
                  state_nxt = WB;
`else
                  state_nxt = MUL;
`endif
               end else if (is_div_op) begin
                  state_nxt = b_zero ? WB : DIV;
               end
            end
            MUL, DIV: if (cnt == '0) state_nxt = FIX;
            FIX: state_nxt = WB;
            WB: begin
               hi_we     = 1'b1;
               lo_we     = 1'b1;
               hi_wdata  = acc[63:32];
               lo_wdata  = acc[31:0];
               done      = 1'b1;
               div_zero  = dz;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         divisor <= '0;
         acc     <= '0;
         neg_hi  <= 1'b0;
         neg_lo  <= 1'b0;
         is_div  <= 1'b0;
         dz      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            divisor <= b_mag;
            is_div  <= is_div_op;
            cnt     <= 6'd31;
            dz      <= 1'b0;
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= is_div_op ? a_neg : (a_neg ^ b_neg);
            acc     <= {32'd0, a_mag};
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul_op) acc <= (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif
            if (is_div_op && b_zero) begin
               acc <= {src_a, 32'hFFFF_FFFF};
               dz  <= 1'b1;
            end
         end else if (!flush) begin
            case (state)
               MUL: begin
                  acc <= mul_step;
                  if (cnt != '0) cnt <= cnt - 6'd1;
               end
               DIV: begin
                  acc <= div_step;
                  if (cnt != '0) cnt <= cnt - 6'd1;
               end
               FIX: acc <= fix_val;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port `start`, input, 1 bit: EX-stage request valid.
REQ-004 SHALL have port `op`, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
REQ-005 SHALL have ports `src_a` and `src_b`, input, 32 bits each: rs and rt operand values.
REQ-006 SHALL have port `flush`, input, 1 bit: pipeline flush; cancels any operation in progress.
REQ-007 SHALL have ports `hi_wdata` and `lo_wdata`, output, 32 bits each: write data for the HI/LO register.
REQ-008 SHALL have ports `hi_we` and `lo_we`, output, 1 bit each: write enables for the HI/LO register.
REQ-009 SHALL have port `stall_req`, output, 1 bit: holds IF/ID/EX stages.
REQ-010 SHALL have port `busy`, output, 1 bit: state is not IDLE.
REQ-011 SHALL have port `done`, output, 1 bit: one-cycle pulse on a multiply or divide result write.
REQ-012 SHALL have port `div_zero`, output, 1 bit: one-cycle pulse, coincident with `done`, when the divisor was 0.

Function
REQ-013 SHALL implement an FSM with states IDLE, MUL, DIV, FIX and WB.
REQ-014 SHALL sample `start`/`op`/`src_*` only in IDLE; `start` in any other state is ignored.
REQ-015 SHALL accept MULT/MULTU in IDLE as follows: latch operands, take magnitudes when signed, go IDLE -> MUL.
- MUL: radix-2 shift-add for exactly 32 cycles, 6-bit counter 31 down to 0.
- Then FIX for 1 cycle: negate the 64-bit product if the signs differ (signed ops only).
- Then WB.
REQ-016 SHALL accept DIV/DIVU in IDLE with `src_b` != 0 as follows: IDLE -> DIV (32-cycle restoring division) -> FIX -> WB.
- FIX sign rule: quotient negative iff operand signs differ; remainder takes the dividend's sign; quotient truncates toward zero.
REQ-017 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo = 0x80000000 and hi = 0x00000000.
REQ-018 SHALL handle divisor 0 by going IDLE -> WB directly, with hi_wdata = `src_a`, lo_wdata = 0xFFFFFFFF, and `div_zero` = 1 in WB.
REQ-019 SHALL, in WB, drive hi_we = lo_we = 1 and done = 1 for exactly one cycle, with hi_wdata = product[63:32] or remainder and lo_wdata = product[31:0] or quotient; the next state is IDLE.
REQ-020 SHALL meet this latency: accept edge ends cycle 0; iterative ops assert the write in cycle 34; the zero-divisor path asserts it in cycle 1.
REQ-021 SHALL handle MTHI/MTLO in IDLE combinationally in the same cycle: hi_we (or lo_we) = 1, corresponding wdata = `src_a`, no state change, no stall, no `done`.
REQ-022 SHALL drive `stall_req` = (IDLE & start & op in {MULT,MULTU,DIV,DIVU}) | state in {MUL,DIV,FIX}.
- `stall_req` is 0 in WB, so the stalled instruction retires on the WB edge.
REQ-023 SHALL drive `busy` = 1 in MUL, DIV, FIX and WB.
REQ-024 SHALL treat `flush` as synchronous with priority over everything except reset:
- next state is IDLE;
- no write occurs in the flush cycle;
- `start` is ignored in that cycle;
- `busy` is 0 the following cycle.
REQ-025 SHALL drive all write enables, `done` and `div_zero` to 0 whenever not specified above.
REQ-026 SHALL hold `hi_wdata` and `lo_wdata` at 0 when no write enable is asserted.

Reset
REQ-027 SHALL, while `rst_n` = 0 at a clock edge: state = IDLE, counter = 0, operand/accumulator registers = 0.
REQ-028 SHALL drive all outputs to 0 during and after reset until a new request; reset mid-operation discards the operation with no write.

Configuration
REQ-029 SHALL support macro MULDIV_FAST_MUL_EN; the multiply path depends on whether it is defined.
- Defined: MULT/MULTU compute the 64-bit product combinationally at accept, path IDLE -> WB, write in cycle 1, `stall_req` high in cycle 0 only.
- Undefined: the 34-cycle iterative path of REQ-015.
- Divide behaviour is identical in both builds.

Verification
REQ-030 SHALL cover: MULT a=0xFFFFFFFF, b=0x00000002 -> cycle 34: hi_we = lo_we = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, done = 1.
REQ-031 SHALL cover: MULTU a=0xFFFFFFFF, b=0x00000002 -> hi = 0x00000001, lo = 0xFFFFFFFE; `stall_req` high in cycles 0-33, low in 34.
REQ-032 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-033 SHALL cover: DIVU a=0x64, b=0 -> cycle 1: div_zero = done = 1, hi = 0x64, lo = 0xFFFFFFFF.
REQ-034 SHALL cover: DIV started, flush in cycle 10 -> no write enable ever; busy = 0 in cycle 11.
- MTLO a=0x1234 in cycle 11 -> lo_we = 1, lo_wdata = 0x1234 in the same cycle.
REQ-035 SHALL cover, with MULDIV_FAST_MUL_EN defined: MULT 3×4 -> cycle 1: hi = 0, lo = 0x0000000C.
- `rst_n` = 0 during an active DIV -> IDLE next edge, no write.
